frame_zero_counter: RTL
=======================

Name: frame_zero_counter

Overview:
- Upstream data is a byte stream with a valid/ready handshake.
- For each byte, the block counts the zero bits, using the same rule as the team's combinational per-byte zero-count function.
- It accumulates those counts over a frame of up to FRAME_LEN bytes, or fewer if in_last ends the frame early.
- It presents the frame total and the frame byte length to the downstream consumer on a valid/ready output handshake.

Parameters:
- FRAME_LEN, default 16: maximum bytes per frame. Legal range 1 to 31.
- CNT_W, default 8: width of out_count. Must satisfy 8*FRAME_LEN <= 2^CNT_W - 1.
- LEN_W, default 5: width of the byte counter and of out_len. Must satisfy FRAME_LEN <= 2^LEN_W - 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  8  byte to be counted.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  this byte ends the frame. Qualified by in_valid.
- in_ready  output  1  block accepts a byte this cycle.
- out_valid  output  1  out_count and out_len hold a completed frame result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_count  output  CNT_W  total zero bits in the frame.
- out_len  output  LEN_W  number of bytes in the frame, 1 to FRAME_LEN.

Behaviour:
- Reset, synchronous active-high: state = ACCUM; acc = 0; byte_cnt = 0; out_valid = 0; out_count = 0; out_len = 0. in_ready is 0 while rst is high.
- Reset mid-frame discards the partial frame. Reset while in HOLD drops the pending result; no transfer occurs.
- in_ready = (state == ACCUM) && !rst. It is combinational from registered state only and has no combinational path from out_ready.
- An input transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- zeros(b) = number of bits of b equal to 0, range 0 to 8. Zero-extend it to CNT_W before adding.
- ACCUM state, on an input transfer:
  - If byte_cnt == FRAME_LEN-1 or in_last == 1: out_count <= acc + zeros(in_data); out_len <= byte_cnt + 1; out_valid <= 1; acc <= 0; byte_cnt <= 0; go to HOLD.
  - Otherwise: acc <= acc + zeros(in_data); byte_cnt <= byte_cnt + 1; stay in ACCUM.
- ACCUM state, no transfer: all state holds. in_last is ignored when in_valid is 0.
- HOLD state:
  - in_ready = 0; input bytes are not accepted and are not counted.
  - out_valid, out_count and out_len hold stable until out_ready is 1.
  - On an output transfer: out_valid <= 0 and go to ACCUM. out_count and out_len keep their last value; their content is don't-care while out_valid is 0.
- Latency: out_valid rises on the clock edge that accepts the final byte, so it is visible the cycle after that byte is presented. out_valid falls on the edge where out_ready is sampled high.
- Back-to-back frames: the first byte of the next frame can be accepted in the cycle after the output transfer. The minimum frame period is frame_bytes + 1 cycles.
- FRAME_LEN = 1: every accepted byte completes a frame with out_len = 1.
- Overflow: none is possible within the legal parameter range. acc never wraps and no saturation logic is required.
- out_ready while out_valid is 0: no effect.
- in_valid with in_ready low: the byte is not consumed. The upstream must hold it.

Test Plan:
- Full frame, defaults: 16 bytes of 0x00 with in_valid continuously high and in_last low. Required: out_valid = 1 the cycle after the 16th byte; out_count = 128; out_len = 16; in_ready = 0 until out_ready.
- Early termination: bytes 0xFF, 0x0F, 0xA5, with in_last on 0xA5. Required: out_count = 0+4+4 = 8; out_len = 3.
- Backpressure: while holding a result with out_count = 8, keep out_ready low for 5 cycles and toggle in_valid with arbitrary data.
  - Required: out_valid, out_count and out_len stable; in_ready = 0.
  - Required: the next frame's count excludes all bytes presented during HOLD.
- Input gaps: frame 0x01, idle 3 cycles, 0x80, idle 2 cycles, 0x00 with in_last. Required: out_count = 7+7+8 = 22; out_len = 3.
- Reset mid-frame: accept 5 bytes of 0x00, assert rst for 1 cycle, then send 0xF0 with in_last.
  - Required: out_count = 4; out_len = 1; out_valid = 0 and in_ready = 0 during the reset cycle.
- Back-to-back frames with out_ready tied high: two 2-byte frames, 0x00/0x00 (last) then 0xFF/0xFF (last).
  - Required results: 16/2, then 0/2.
  - Required: exactly one cycle with in_ready = 0 between the frames; no bytes lost or duplicated.

Source files
------------

// File: rtl/frame_zero_counter.sv
// ============================================================================
// Module  : frame_zero_counter
// Brief   : Counts zero bits per byte and reports per-frame totals and lengths.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_zero_counter #(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int LEN_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [LEN_W-1:0] out_len
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(FRAME_LEN - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] acc, acc_next;
    logic [LEN_W-1:0] byte_cnt, byte_cnt_next;
    logic             out_valid_next;
    logic [CNT_W-1:0] out_count_next;
    logic [LEN_W-1:0] out_len_next;
    logic             in_fire;
    logic [3:0]       zero_cnt;
    logic [CNT_W-1:0] acc_sum;

    function automatic logic [3:0] zeros(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, ~b[i]};
        end
        return n;
    endfunction

    // Ready depends only on registered state and reset, never on out_ready.
    assign in_ready = (state == ACCUM) && !rst;
    assign in_fire  = in_valid && in_ready;
    assign zero_cnt = zeros(in_data);
    assign acc_sum  = acc + {{(CNT_W-4){1'b0}}, zero_cnt};

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        byte_cnt_next  = byte_cnt;
        out_valid_next = out_valid;
        out_count_next = out_count;
        out_len_next   = out_len;
        case (state)
            ACCUM: begin
                if (in_fire) begin
                    if ((byte_cnt == LAST_IDX) || in_last) begin
                        out_count_next = acc_sum;
                        out_len_next   = byte_cnt + 1'b1;
                        out_valid_next = 1'b1;
                        acc_next       = '0;
                        byte_cnt_next  = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next       = acc_sum;
                        byte_cnt_next  = byte_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_len   <= '0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            byte_cnt  <= byte_cnt_next;
            out_valid <= out_valid_next;
            out_count <= out_count_next;
            out_len   <= out_len_next;
        end
    end

endmodule

`default_nettype wire
